// File: rtl/vreg_xbar_rr.sv
// NUM_PORT x NUM_BANK vector-register crossbar with per-bank round-robin arbitration,
// registered bank commands and fixed-latency response routing back to the requesting port.
module vreg_xbar_rr #(
  parameter int NUM_PORT = 4,
  parameter int NUM_BANK = 8,
  parameter int DEPTH    = 64,
  parameter int WIDTH    = 64,
  parameter int RD_LAT   = 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int BW = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
  localparam int PW = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PORT-1:0]       req_vld,
  output logic [NUM_PORT-1:0]       req_rdy,
  input  logic [NUM_PORT*BW-1:0]    req_bank,
  input  logic [NUM_PORT-1:0]       req_we,
  input  logic [NUM_PORT*AW-1:0]    req_addr,
  input  logic [NUM_PORT*WIDTH-1:0] req_wdata,
  output logic [NUM_BANK-1:0]       bank_en,
  output logic [NUM_BANK-1:0]       bank_we,
  output logic [NUM_BANK*AW-1:0]    bank_addr,
  output logic [NUM_BANK*WIDTH-1:0] bank_wdata,
  input  logic [NUM_BANK*WIDTH-1:0] bank_rdata,
  output logic [NUM_PORT-1:0]       rsp_vld,
  output logic [NUM_PORT-1:0]       rsp_we,
  output logic [NUM_PORT-1:0]       rsp_err,
  output logic [NUM_PORT*WIDTH-1:0] rsp_rdata
);

  logic [BW-1:0]       port_bank_s [NUM_PORT];
  logic [NUM_PORT-1:0] port_oor_s;
  logic [NUM_PORT-1:0] hs_s;
  logic [PW-1:0]       ptr_r [NUM_BANK];
  logic [PW-1:0]       win_s [NUM_BANK];
  logic [NUM_BANK-1:0] gnt_s;

  logic [RD_LAT:0]     tag_vld_r [NUM_BANK];
  logic [RD_LAT:0]     tag_we_r  [NUM_BANK];
  logic [PW-1:0]       tag_id_r  [NUM_BANK][RD_LAT+1];
  logic [RD_LAT:0]     err_r     [NUM_PORT];

  // Split the flat bank field per port and flag targets beyond the last bank.
  always_comb begin
    for (int p = 0; p < NUM_PORT; p++) begin
      port_bank_s[p] = req_bank[p*BW +: BW];
      port_oor_s[p]  = (32'(req_bank[p*BW +: BW]) >= 32'(NUM_BANK));
    end
  end

  // Per-bank round-robin: first requester at or after the pointer, wrapping to port 0.
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      logic found;
      found    = 1'b0;
      gnt_s[b] = 1'b0;
      win_s[b] = '0;
      for (int i = 0; i < NUM_PORT; i++) begin
        int idx;
        idx = int'(ptr_r[b]) + i;
        if (idx >= NUM_PORT) begin
          idx = idx - NUM_PORT;
        end else begin
          idx = idx;
        end
        if (!found && req_vld[idx] && !port_oor_s[idx] && (port_bank_s[idx] == BW'(b))) begin
          found    = 1'b1;
          gnt_s[b] = 1'b1;
          win_s[b] = PW'(idx);
        end else begin
          found = found;
        end
      end
    end
  end

  // Out-of-range requests are accepted at once and answered through the error pipeline.
  always_comb begin
    req_rdy = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (reset) begin
        req_rdy[p] = 1'b0;
      end else if (port_oor_s[p]) begin
        req_rdy[p] = req_vld[p];
      end else begin
        for (int b = 0; b < NUM_BANK; b++) begin
          req_rdy[p] = req_rdy[p] | (gnt_s[b] && (win_s[b] == PW'(p)));
        end
      end
    end
  end

  assign hs_s = req_vld & req_rdy;

  // Bank command registers and round-robin pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        ptr_r[b] <= '0;
      end
      bank_en    <= '0;
      bank_we    <= '0;
      bank_addr  <= '0;
      bank_wdata <= '0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (gnt_s[b]) begin
          ptr_r[b]                     <= (32'(win_s[b]) == 32'(NUM_PORT - 1)) ? '0 : win_s[b] + PW'(1);
          bank_en[b]                   <= 1'b1;
          bank_we[b]                   <= req_we[win_s[b]];
          bank_addr[b*AW +: AW]        <= req_addr[win_s[b]*AW +: AW];
          bank_wdata[b*WIDTH +: WIDTH] <= req_wdata[win_s[b]*WIDTH +: WIDTH];
        end else begin
          bank_en[b] <= 1'b0;
          bank_we[b] <= 1'b0;
        end
      end
    end
  end

  // Tag and error pipelines; stage RD_LAT lines up with the bank read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        tag_vld_r[b] <= '0;
        tag_we_r[b]  <= '0;
        for (int s = 0; s <= RD_LAT; s++) begin
          tag_id_r[b][s] <= '0;
        end
      end
      for (int p = 0; p < NUM_PORT; p++) begin
        err_r[p] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        tag_vld_r[b]   <= {tag_vld_r[b][RD_LAT-1:0], gnt_s[b]};
        tag_we_r[b]    <= {tag_we_r[b][RD_LAT-1:0], gnt_s[b] & req_we[win_s[b]]};
        tag_id_r[b][0] <= win_s[b];
        for (int s = 1; s <= RD_LAT; s++) begin
          tag_id_r[b][s] <= tag_id_r[b][s-1];
        end
      end
      for (int p = 0; p < NUM_PORT; p++) begin
        err_r[p] <= {err_r[p][RD_LAT-1:0], hs_s[p] & port_oor_s[p]};
      end
    end
  end

  // Route the last tag stage of every bank back to its originating port.
  always_comb begin
    rsp_vld   = '0;
    rsp_we    = '0;
    rsp_err   = '0;
    rsp_rdata = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      logic [WIDTH-1:0] data_v;
      logic             vld_v;
      logic             we_v;
      data_v = '0;
      vld_v  = 1'b0;
      we_v   = 1'b0;
      for (int b = 0; b < NUM_BANK; b++) begin
        if (tag_vld_r[b][RD_LAT] && (tag_id_r[b][RD_LAT] == PW'(p))) begin
          vld_v  = 1'b1;
          we_v   = tag_we_r[b][RD_LAT];
          data_v = tag_we_r[b][RD_LAT] ? '0 : bank_rdata[b*WIDTH +: WIDTH];
        end else begin
          vld_v = vld_v;
        end
      end
      if (reset) begin
        rsp_vld[p] = 1'b0;
      end else begin
        rsp_vld[p]                  = vld_v | err_r[p][RD_LAT];
        rsp_we[p]                   = we_v;
        rsp_err[p]                  = err_r[p][RD_LAT];
        rsp_rdata[p*WIDTH +: WIDTH] = data_v;
      end
    end
  end

endmodule
